fd_multi_prog: RTL and testbench



---
 rtl/fd_pkg.sv | 17 +
 rtl/fd_channel.sv | 150 +++++++++++++++
 rtl/fd_multi_prog.sv | 62 ++++++
 tb/tb_fd_multi_prog.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared types and helpers for the multi-channel programmable divider.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package fd_pkg;

    localparam int FD_DEF_NUM_CH = 4;
    localparam int FD_DEF_DIV_W  = 24;

    // Widest divisor the helpers handle; channel DIV_W must not exceed this.
    typedef logic [FD_DEF_DIV_W-1:0] div_t;

    // ceil(d/2) without overflow: the result never exceeds d.
    function automatic div_t half_ceil(input div_t d);
        return (d >> 1) + div_t'(d[0]);
    endfunction

endpackage

// File: rtl/fd_channel.sv
// One divider channel: counter, shadow/active divisor, tick and square-wave outputs.
// Latency: outputs registered; a new divisor takes effect on the terminal-count edge.
// Backpressure: none; writes are accepted every cycle and staged in a shadow register.
// Optional FD_DUTY_EN adds a staged programmable high-time (otherwise ceil(D/2)).
module fd_channel
    import fd_pkg::*;
#(
    parameter int DIV_W       = FD_DEF_DIV_W,
    parameter int DEFAULT_DIV = 25_000_000
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_we,
    input  logic [DIV_W-1:0] i_div,
`ifdef FD_DUTY_EN
    input  logic             i_duty_we,
    input  logic [DIV_W-1:0] i_duty,
`endif
    input  logic             i_sync_clr,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_pending
);

    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] RST_CNT  = (DEFAULT_DIV == 0) ? '0 : DIV_W'(DEFAULT_DIV - 1);
    localparam logic [DIV_W-1:0] RST_HIGH = DIV_W'(half_ceil(div_t'(RST_DIV)));

    logic [DIV_W-1:0] r_active;
    logic [DIV_W-1:0] r_shadow;
    logic [DIV_W-1:0] r_cnt;
    logic             r_pending;
    logic             r_tick;
    logic             r_clk_out;

    logic             w_enabled;
    logic             w_hit;
    logic             w_cfg_wr;
    logic [DIV_W-1:0] w_stage_div;
    logic [DIV_W-1:0] w_stage_cnt;
    logic [DIV_W-1:0] w_stage_high;
    logic [DIV_W-1:0] w_act_high;
    logic [DIV_W-1:0] w_cnt_inc;

    // Terminal count, and the divisor that would be applied at this edge
    // (a same-cycle write bypasses the shadow so it is not lost).
    always_comb begin
        w_enabled   = (r_active != '0);
        w_hit       = w_enabled && (r_cnt == r_active - ONE);
        w_stage_div = i_we ? i_div : r_shadow;
        w_stage_cnt = (w_stage_div == '0) ? '0 : (w_stage_div - ONE);
        w_cnt_inc   = r_cnt + ONE;
    end

`ifdef FD_DUTY_EN
    logic [DIV_W-1:0] r_active_h;
    logic [DIV_W-1:0] r_shadow_h;

    // High-time is staged and applied at exactly the same points as the divisor.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_active_h <= RST_HIGH;
            r_shadow_h <= RST_HIGH;
        end else if (i_sync_clr || w_hit) begin
            r_active_h <= w_stage_high;
            r_shadow_h <= w_stage_high;
        end else if (!w_enabled) begin
            if (i_duty_we) begin
                r_active_h <= i_duty;
                r_shadow_h <= i_duty;
            end
        end else if (i_duty_we) begin
            r_shadow_h <= i_duty;
        end
    end

    // Programmed high-time; anything >= D simply keeps the output high.
    always_comb begin
        w_cfg_wr     = i_we | i_duty_we;
        w_stage_high = i_duty_we ? i_duty : r_shadow_h;
        w_act_high   = r_active_h;
    end
`else
    // Fixed high-time of ceil(D/2): D=5 gives high 3 / low 2.
    always_comb begin
        w_cfg_wr     = i_we;
        w_stage_high = DIV_W'(half_ceil(div_t'(w_stage_div)));
        w_act_high   = DIV_W'(half_ceil(div_t'(r_active)));
    end

    // RST_HIGH only matters when the high-time is programmable.
    logic w_unused_rst_high;
    assign w_unused_rst_high = ^RST_HIGH;
`endif

    // Counter, divisor staging/apply and registered outputs.
    // Priority: reset, then sync_clr, then idle channel, then terminal count.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_active  <= RST_DIV;
            r_shadow  <= RST_DIV;
            r_cnt     <= RST_CNT;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else if (i_sync_clr) begin
            // Park every channel at its last count so all tick on the next edge.
            r_active  <= w_stage_div;
            r_shadow  <= w_stage_div;
            r_cnt     <= w_stage_cnt;
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else if (!w_enabled) begin
            // Idle channel: a write takes effect at once and ticks on the next edge.
            if (i_we) begin
                r_active <= i_div;
                r_shadow <= i_div;
                r_cnt    <= w_stage_cnt;
            end else begin
                r_cnt <= '0;
            end
            r_pending <= 1'b0;
            r_tick    <= 1'b0;
            r_clk_out <= 1'b0;
        end else if (w_hit) begin
            // Period boundary: apply the staged divisor, restart from 0.
            // A staged 0 still ticks here, then the channel goes idle.
            r_active  <= w_stage_div;
            r_shadow  <= w_stage_div;
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_tick    <= 1'b1;
            r_clk_out <= (w_stage_div != '0) && (w_stage_high != '0);
        end else begin
            // Mid-period: keep counting on the current divisor, stage any write.
            r_shadow  <= w_stage_div;
            r_cnt     <= w_cnt_inc;
            r_pending <= r_pending | w_cfg_wr;
            r_tick    <= 1'b0;
            r_clk_out <= (w_cnt_inc < w_act_high);
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_pending = r_pending;

endmodule

// File: rtl/fd_multi_prog.sv
// Multi-channel programmable clock divider with glitch-free divisor updates and phase clear.
// Latency: all outputs registered; first tick one edge after reset release or sync_clr.
// Backpressure: none; config writes to an out-of-range channel are dropped.
// Optional FD_DUTY_EN adds cfg_duty_we/cfg_duty for a programmable high-time.
module fd_multi_prog
    import fd_pkg::*;
#(
    parameter int NUM_CH      = FD_DEF_NUM_CH,
    parameter int DIV_W       = FD_DEF_DIV_W,
    parameter int DEFAULT_DIV = 25_000_000,
    // Widen to address (and reject) indices beyond NUM_CH-1.
    parameter int CFG_CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_we,
    input  logic [CFG_CH_W-1:0] cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
`ifdef FD_DUTY_EN
    input  logic                cfg_duty_we,
    input  logic [DIV_W-1:0]    cfg_duty,
`endif
    input  logic                sync_clr,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick,
    output logic [NUM_CH-1:0]   cfg_pending
);

    logic [NUM_CH-1:0] w_ch_we;
`ifdef FD_DUTY_EN
    logic [NUM_CH-1:0] w_ch_duty_we;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Per-channel write decode; indices >= NUM_CH match no channel.
        always_comb begin
            w_ch_we[i] = cfg_we && (cfg_ch == CFG_CH_W'(i));
`ifdef FD_DUTY_EN
            w_ch_duty_we[i] = cfg_duty_we && (cfg_ch == CFG_CH_W'(i));
`endif
        end

        fd_channel #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .i_clk      (clk),
            .i_reset    (reset),
            .i_we       (w_ch_we[i]),
            .i_div      (cfg_div),
`ifdef FD_DUTY_EN
            .i_duty_we  (w_ch_duty_we[i]),
            .i_duty     (cfg_duty),
`endif
            .i_sync_clr (sync_clr),
            .o_clk_out  (clk_out[i]),
            .o_tick     (tick[i]),
            .o_pending  (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_fd_multi_prog.sv
// Scoreboard bench for fd_multi_prog: stimulus pushes expected outputs, monitor pops and compares.
// Reference model tracks, per channel, edges-left-until-tick and phase within the period.
module tb_fd_multi_prog;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int DEF = 4;
    localparam int CW  = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic           cfg_we;
    logic [CW-1:0]  cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic           sync_clr;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] cfg_pending;

    always #10 clk = ~clk;

    fd_multi_prog #(
        .NUM_CH      (NCH),
        .DIV_W       (DW),
        .DEFAULT_DIV (DEF),
        .CFG_CH_W    (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_div     (cfg_div),
`ifdef FD_DUTY_EN
        .cfg_duty_we (1'b0),
        .cfg_duty    ('0),
`endif
        .sync_clr    (sync_clr),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    int checks = 0;
    int errors = 0;
    bit done   = 1'b0;

    logic [3*NCH-1:0] sb_q[$];

    // Reference model state (per channel)
    int m_per[NCH];   // period in force (0 = idle)
    int m_stg[NCH];   // last written divisor awaiting application
    int m_left[NCH];  // edges remaining before the next tick edge
    bit m_pend[NCH];
    bit m_tick[NCH];
    bit m_ck[NCH];

    task automatic cmp(input string name, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_edge(input bit rst, input bit we, input int ch, input int div, input bit clr);
        for (int c = 0; c < NCH; c++) begin
            bit w;
            int nd;
            w  = we && (ch == c);
            nd = w ? div : m_stg[c];
            if (rst) begin
                m_per[c] = DEF; m_stg[c] = DEF; m_left[c] = 0;
                m_pend[c] = 0; m_tick[c] = 0; m_ck[c] = 0;
            end else if (clr) begin
                m_per[c] = nd; m_stg[c] = nd; m_left[c] = 0;
                m_pend[c] = 0; m_tick[c] = 0; m_ck[c] = 0;
            end else if (m_per[c] == 0) begin
                if (w) begin
                    m_per[c] = div; m_stg[c] = div; m_left[c] = 0;
                end
                m_pend[c] = 0; m_tick[c] = 0; m_ck[c] = 0;
            end else if (m_left[c] == 0) begin
                // Tick edge: new period starts at phase 0 (high for any D >= 1).
                m_per[c]  = nd; m_stg[c] = nd;
                m_left[c] = (nd > 0) ? nd - 1 : 0;
                m_pend[c] = 0; m_tick[c] = 1; m_ck[c] = (nd > 0);
            end else begin
                int phase;
                m_left[c] = m_left[c] - 1;
                phase     = m_per[c] - 1 - m_left[c];
                m_tick[c] = 0;
                m_ck[c]   = (phase < (m_per[c] + 1) / 2);
                if (w) begin
                    m_stg[c]  = div;
                    m_pend[c] = 1;
                end
            end
        end
    endtask

    task automatic step(input bit rst, input bit we, input int ch, input int div, input bit clr);
        logic [NCH-1:0] e_ck, e_tk, e_pd;
        reset    = rst;
        cfg_we   = we;
        cfg_ch   = CW'(ch);
        cfg_div  = DW'(div);
        sync_clr = clr;
        model_edge(rst, we, ch, div, clr);
        for (int c = 0; c < NCH; c++) begin
            e_ck[c] = m_ck[c];
            e_tk[c] = m_tick[c];
            e_pd[c] = m_pend[c];
        end
        sb_q.push_back({e_ck, e_tk, e_pd});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    // Monitor: one expected entry per edge, compared just after the edge.
    initial begin : monitor
        logic [3*NCH-1:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (!done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow at %0t: got 0 entries expected 1", $time);
                end else begin
                    exp = sb_q.pop_front();
                    cmp("clk_out",     clk_out,     exp[3*NCH-1:2*NCH]);
                    cmp("tick",        tick,        exp[2*NCH-1:NCH]);
                    cmp("cfg_pending", cfg_pending, exp[NCH-1:0]);
                end
            end
        end
    end

    initial begin : stimulus
        // Reset, then free-run at the default divisor.
        repeat (3) step(1, 0, 0, 0, 0);
        idle(12);

        // Divisor 6 on ch1 written at edge 2 after release.
        repeat (2) step(1, 0, 0, 0, 0);
        idle(1);
        step(0, 1, 1, 6, 0);
        idle(20);

        // Disable ch2, idle, re-enable with 3.
        step(0, 1, 2, 0, 0);
        idle(10);
        step(0, 1, 2, 3, 0);
        idle(10);

        // Reprogram ch0/ch3 while running, then phase-clear everything.
        step(0, 1, 0, 3, 0);
        step(0, 1, 3, 5, 0);
        idle(2);
        step(0, 0, 0, 0, 1);
        idle(20);

        // Out-of-range channel index.
        step(0, 1, 4, 7, 0);
        idle(6);

        // Reset mid-period with a pending write.
        step(0, 1, 0, 9, 0);
        idle(1);
        step(1, 0, 0, 0, 0);
        idle(10);

        // Randomised traffic, including same-cycle write + clear and rare resets.
        for (int i = 0; i < 1500; i++) begin
            bit rst, we, clr;
            rst = ($urandom_range(0, 299) == 0);
            we  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 39) == 0);
            step(rst, we, int'($urandom_range(0, 4)), int'($urandom_range(0, 10)), clr);
        end
        idle(4);

        done = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
